// File: rtl/bomb_scheduler.sv
// Bomb slot scheduler: grants placements from two players into a shared slot pool,
// runs per-slot fuse/blast timers with chain reactions, registers bomb and explosion maps.
module bomb_scheduler #(
  parameter int         NUM_SLOTS      = 4,
  parameter int         MAX_PER_PLAYER = 2,
  parameter logic [7:0] FUSE_TICKS     = 8'd120,
  parameter logic [7:0] BLAST_TICKS    = 8'd30,
  parameter int         RANGE          = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         freeze,
  input  logic         p1_place,
  input  logic         p2_place,
  input  logic [7:0]   p1_cor,
  input  logic [7:0]   p2_cor,
  output logic         p1_ack,
  output logic         p2_ack,
  output logic [255:0] bomb_map,
  output logic [255:0] o_explode
);

  typedef enum logic [1:0] {S_IDLE, S_FUSE, S_BLAST} slot_state_e;
  typedef enum logic {OWN_P1, OWN_P2} owner_e;

  slot_state_e state_q [NUM_SLOTS];
  slot_state_e state_d [NUM_SLOTS];
  owner_e      owner_q [NUM_SLOTS];
  owner_e      owner_d [NUM_SLOTS];
  logic [7:0]  cor_q   [NUM_SLOTS];
  logic [7:0]  cor_d   [NUM_SLOTS];
  logic [7:0]  cnt_q   [NUM_SLOTS];
  logic [7:0]  cnt_d   [NUM_SLOTS];

  owner_e         rr_q, rr_d;
  logic           p1_ack_q, p2_ack_q;
  logic [255:0]   bomb_map_q, bomb_map_d;
  logic [255:0]   explode_q, explode_d;

  logic [3:0]           p1_live, p2_live, idle_cnt;
  logic                 p1_occ, p2_occ;
  logic [NUM_SLOTS-1:0] first_idle, second_idle;
  logic                 p1_ok, p2_ok;
  logic                 p1_gnt, p2_gnt;
  logic [NUM_SLOTS-1:0] p1_slot, p2_slot;
  logic [255:0]         fuse_map, cross_map;
  logic [4:0]           row5, col5, kk, up, dn;

  // Pool occupancy: live counts, cell occupancy, and the two lowest IDLE slots.
  always_comb begin
    p1_live     = '0;
    p2_live     = '0;
    idle_cnt    = '0;
    p1_occ      = 1'b0;
    p2_occ      = 1'b0;
    first_idle  = '0;
    second_idle = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (state_q[s] == S_IDLE) begin
        if (idle_cnt == 4'd0) begin
          first_idle[s] = 1'b1;
        end else if (idle_cnt == 4'd1) begin
          second_idle[s] = 1'b1;
        end
        idle_cnt = idle_cnt + 4'd1;
      end else begin
        if (owner_q[s] == OWN_P1) begin
          p1_live = p1_live + 4'd1;
        end else begin
          p2_live = p2_live + 4'd1;
        end
        if (cor_q[s] == p1_cor) p1_occ = 1'b1;
        if (cor_q[s] == p2_cor) p2_occ = 1'b1;
      end
    end
  end

  always_comb begin
    p1_ok   = p1_place && !freeze && (idle_cnt != 4'd0) &&
              (p1_live < 4'(MAX_PER_PLAYER)) && !p1_occ;
    p2_ok   = p2_place && !freeze && (idle_cnt != 4'd0) &&
              (p2_live < 4'(MAX_PER_PLAYER)) && !p2_occ;
    p1_gnt  = 1'b0;
    p2_gnt  = 1'b0;
    p1_slot = '0;
    p2_slot = '0;
    rr_d    = rr_q;
    if (p1_ok && p2_ok) begin
      if ((p1_cor != p2_cor) && (idle_cnt >= 4'd2)) begin
        p1_gnt  = 1'b1;
        p2_gnt  = 1'b1;
        p1_slot = first_idle;
        p2_slot = second_idle;
      end else begin
        // Contested: pointer picks the winner, then hands priority to the other player.
        rr_d = (rr_q == OWN_P1) ? OWN_P2 : OWN_P1;
        if (rr_q == OWN_P1) begin
          p1_gnt  = 1'b1;
          p1_slot = first_idle;
        end else begin
          p2_gnt  = 1'b1;
          p2_slot = first_idle;
        end
      end
    end else if (p1_ok) begin
      p1_gnt  = 1'b1;
      p1_slot = first_idle;
    end else if (p2_ok) begin
      p2_gnt  = 1'b1;
      p2_slot = first_idle;
    end
  end

  // Per-slot FSM next state; a chain hit comes from the registered explosion map.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      state_d[s] = state_q[s];
      owner_d[s] = owner_q[s];
      cor_d[s]   = cor_q[s];
      cnt_d[s]   = cnt_q[s];
      if (!freeze) begin
        case (state_q[s])
          S_IDLE: begin
            if (p1_slot[s]) begin
              state_d[s] = S_FUSE;
              owner_d[s] = OWN_P1;
              cor_d[s]   = p1_cor;
              cnt_d[s]   = FUSE_TICKS;
            end else if (p2_slot[s]) begin
              state_d[s] = S_FUSE;
              owner_d[s] = OWN_P2;
              cor_d[s]   = p2_cor;
              cnt_d[s]   = FUSE_TICKS;
            end
          end
          S_FUSE: begin
            if (explode_q[cor_q[s]] || (tick && (cnt_q[s] == 8'd1))) begin
              state_d[s] = S_BLAST;
              cnt_d[s]   = BLAST_TICKS;
            end else if (tick) begin
              cnt_d[s] = cnt_q[s] - 8'd1;
            end
          end
          S_BLAST: begin
            if (tick && (cnt_q[s] == 8'd1)) begin
              state_d[s] = S_IDLE;
              cnt_d[s]   = 8'd0;
            end else if (tick) begin
              cnt_d[s] = cnt_q[s] - 8'd1;
            end
          end
          default: state_d[s] = S_IDLE;
        endcase
      end
    end
  end

  // Crosses are built arm by arm with 5-bit coordinates so edge clipping never wraps.
  always_comb begin
    fuse_map  = '0;
    cross_map = '0;
    row5      = '0;
    col5      = '0;
    kk        = '0;
    up        = '0;
    dn        = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (state_q[s] == S_FUSE) fuse_map[cor_q[s]] = 1'b1;
      if (state_q[s] == S_BLAST) begin
        row5 = {1'b0, cor_q[s][7:4]};
        col5 = {1'b0, cor_q[s][3:0]};
        for (int k = 0; k <= RANGE; k++) begin
          kk = 5'(k);
          up = col5 + kk;
          if (up <= 5'd15) cross_map[{row5[3:0], up[3:0]}] = 1'b1;
          if (col5 >= kk) begin
            dn = col5 - kk;
            cross_map[{row5[3:0], dn[3:0]}] = 1'b1;
          end
          up = row5 + kk;
          if (up <= 5'd15) cross_map[{up[3:0], col5[3:0]}] = 1'b1;
          if (row5 >= kk) begin
            dn = row5 - kk;
            cross_map[{dn[3:0], col5[3:0]}] = 1'b1;
          end
        end
      end
    end
    bomb_map_d = freeze ? bomb_map_q : fuse_map;
    explode_d  = freeze ? explode_q  : cross_map;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= S_IDLE;
        owner_q[s] <= OWN_P1;
        cor_q[s]   <= '0;
        cnt_q[s]   <= '0;
      end
      rr_q       <= OWN_P1;
      p1_ack_q   <= 1'b0;
      p2_ack_q   <= 1'b0;
      bomb_map_q <= '0;
      explode_q  <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= state_d[s];
        owner_q[s] <= owner_d[s];
        cor_q[s]   <= cor_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
      rr_q       <= rr_d;
      p1_ack_q   <= p1_gnt;
      p2_ack_q   <= p2_gnt;
      bomb_map_q <= bomb_map_d;
      explode_q  <= explode_d;
    end
  end

  assign p1_ack    = p1_ack_q;
  assign p2_ack    = p2_ack_q;
  assign bomb_map  = bomb_map_q;
  assign o_explode = explode_q;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler: vector table for arbitration/limits, hand sequences for timers,
// clipping, chain, freeze and reset.
module tb_bomb_scheduler;
  logic         clk = 1'b0;
  logic         reset, tick, freeze, p1_place, p2_place;
  logic [7:0]   p1_cor, p2_cor;
  logic         p1_ack, p2_ack;
  logic [255:0] bomb_map, o_explode;

  int errors = 0;
  int checks = 0;

  bomb_scheduler #(
    .NUM_SLOTS(4), .MAX_PER_PLAYER(2), .FUSE_TICKS(8'd10), .BLAST_TICKS(8'd2), .RANGE(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .freeze(freeze),
    .p1_place(p1_place), .p2_place(p2_place), .p1_cor(p1_cor), .p2_cor(p2_cor),
    .p1_ack(p1_ack), .p2_ack(p2_ack), .bomb_map(bomb_map), .o_explode(o_explode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic a1;
    logic a2;
  } ack_exp_t;
  ack_exp_t sb[$];

  typedef struct {
    logic       rst;
    logic       frz;
    logic       pl1;
    logic [7:0] c1;
    logic       pl2;
    logic [7:0] c2;
    logic       e1;
    logic       e2;
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] bit_of(input logic [7:0] c);
    logic [255:0] m;
    m = '0;
    m[c] = 1'b1;
    return m;
  endfunction

  // Reference cross: every cell within distance 2 on the same row or column.
  function automatic logic [255:0] cross_of(input logic [7:0] c);
    logic [255:0] m;
    int r0, c0, r, cc;
    m  = '0;
    r0 = int'(c[7:4]);
    c0 = int'(c[3:0]);
    for (int i = 0; i < 256; i++) begin
      r  = i / 16;
      cc = i % 16;
      if ((r == r0 && cc - c0 <= 2 && c0 - cc <= 2) ||
          (cc == c0 && r - r0 <= 2 && r0 - r <= 2))
        m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one request cycle; the expected acks ride the scoreboard until the ack cycle.
  task automatic request(input logic pl1, input logic [7:0] c1, input logic pl2,
                         input logic [7:0] c2, input logic e1, input logic e2,
                         input string name);
    ack_exp_t e, got;
    p1_place = pl1;
    p1_cor   = c1;
    p2_place = pl2;
    p2_cor   = c2;
    e.a1 = e1;
    e.a2 = e2;
    sb.push_back(e);
    @(negedge clk);
    p1_place = 1'b0;
    p2_place = 1'b0;
    got = sb.pop_front();
    chk1({name, " p1_ack"}, p1_ack, got.a1);
    chk1({name, " p2_ack"}, p2_ack, got.a2);
  endtask

  initial begin
    vec_t         tbl [13];
    logic [7:0]   l55 [9];
    logic [7:0]   ledge [10];
    logic [255:0] m55, medge, exp_map, exp_ex;

    reset = 1'b1; tick = 1'b0; freeze = 1'b0;
    p1_place = 1'b0; p2_place = 1'b0; p1_cor = '0; p2_cor = '0;

    l55   = '{8'h55, 8'h54, 8'h53, 8'h56, 8'h57, 8'h45, 8'h35, 8'h65, 8'h75};
    ledge = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h20, 8'h0F, 8'h0E, 8'h0D, 8'h1F, 8'h2F};
    m55 = '0;
    foreach (l55[i]) m55[l55[i]] = 1'b1;
    medge = '0;
    foreach (ledge[i]) medge[ledge[i]] = 1'b1;

    //           rst   frz   pl1   c1     pl2   c2     e1    e2
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 8'h33, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 8'h33, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 8'h44, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 8'h20, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 8'h66, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h21, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h23, 1'b0, 1'b0};

    @(negedge clk);
    chk1("reset p1_ack", p1_ack, 1'b0);
    chk1("reset p2_ack", p2_ack, 1'b0);
    chk256("reset bomb_map", bomb_map, '0);
    chk256("reset o_explode", o_explode, '0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      freeze = tbl[i].frz;
      request(tbl[i].pl1, tbl[i].c1, tbl[i].pl2, tbl[i].c2, tbl[i].e1, tbl[i].e2,
              $sformatf("vec%0d", i));
      freeze = 1'b0;
    end
    chk256("limits bomb_map", bomb_map,
           bit_of(8'h11) | bit_of(8'h12) | bit_of(8'h21) | bit_of(8'h22));

    // Single bomb, tick every cycle including the grant cycle.
    do_reset();
    tick = 1'b1;
    request(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, "single");
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp_map = (k <= 10) ? bit_of(8'h55) : '0;
      exp_ex  = (k == 11 || k == 12) ? m55 : '0;
      chk256($sformatf("single map k%0d", k), bomb_map, exp_map);
      chk256($sformatf("single explode k%0d", k), o_explode, exp_ex);
      if (k == 1) chk1("single ack pulse", p1_ack, 1'b0);
    end
    tick = 1'b0;

    // Corner bombs blast together; the union must contain no wrapped cells.
    do_reset();
    tick = 1'b1;
    request(1'b1, 8'h00, 1'b1, 8'h0F, 1'b1, 1'b1, "edge pair");
    repeat (10) @(negedge clk);
    chk256("edge pre", o_explode, '0);
    @(negedge clk);
    chk256("edge clip a", o_explode, medge);
    @(negedge clk);
    chk256("edge clip b", o_explode, medge);
    @(negedge clk);
    chk256("edge clear", o_explode, '0);
    chk256("edge map clear", bomb_map, '0);
    tick = 1'b0;

    // Chain: ticks stop once A blasts, so B can only enter BLAST through the chain.
    do_reset();
    request(1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, "chain A");
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    request(1'b0, 8'h00, 1'b1, 8'h24, 1'b0, 1'b1, "chain B");
    tick = 1'b1;
    repeat (6) @(negedge clk);
    chk256("chain fuse map", bomb_map, bit_of(8'h22) | bit_of(8'h24));
    @(negedge clk);
    tick = 1'b0;
    chk256("chain pre", o_explode, '0);
    @(negedge clk);
    chk256("chain A cross", o_explode, cross_of(8'h22));
    chk256("chain B fuse a", bomb_map, bit_of(8'h24));
    @(negedge clk);
    chk256("chain A only", o_explode, cross_of(8'h22));
    chk256("chain B fuse b", bomb_map, bit_of(8'h24));
    @(negedge clk);
    chk256("chain union", o_explode, cross_of(8'h22) | cross_of(8'h24));
    chk256("chain map empty", bomb_map, '0);
    repeat (3) @(negedge clk);
    chk256("chain union hold", o_explode, cross_of(8'h22) | cross_of(8'h24));

    // Freeze for 20 ticks mid-fuse, then the remaining 6 ticks finish the countdown.
    do_reset();
    request(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, "frz place");
    tick = 1'b1;
    repeat (4) @(negedge clk);
    freeze = 1'b1;
    request(1'b0, 8'h00, 1'b1, 8'h88, 1'b0, 1'b0, "frz drop");
    repeat (19) @(negedge clk);
    chk256("frz map hold", bomb_map, bit_of(8'h77));
    chk256("frz explode hold", o_explode, '0);
    freeze = 1'b0;
    repeat (5) @(negedge clk);
    chk256("frz resume explode", o_explode, '0);
    chk256("frz resume map", bomb_map, bit_of(8'h77));
    @(negedge clk);
    chk256("frz last fuse explode", o_explode, '0);
    chk256("frz last fuse map", bomb_map, bit_of(8'h77));
    @(negedge clk);
    tick = 1'b0;
    chk256("frz blast", o_explode, cross_of(8'h77));
    chk256("frz blast map", bomb_map, '0);

    // Asynchronous reset while a blast is showing and an ack is high.
    request(1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 1'b0, "pre-reset place");
    chk256("pre-reset explode", o_explode, cross_of(8'h77));
    reset = 1'b1;
    #1;
    chk1("async reset p1_ack", p1_ack, 1'b0);
    chk256("async reset explode", o_explode, '0);
    chk256("async reset map", bomb_map, '0);
    @(negedge clk);
    reset = 1'b0;
    request(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, "post-reset place");
    @(negedge clk);
    chk256("post-reset map", bomb_map, bit_of(8'h5A));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
